// File: rtl/serial_sub_if.sv
`default_nettype none
// ============================================================================
//  Module      : serial_sub_if
//  Description : Handshake bundle for the bit-serial subtractor.
//                Operand side : start_valid / start_ready, data1, data2
//                Result side  : done_valid / done_ready, diff
//                master = producer/consumer (drives operands, takes result)
//                slave  = the subtractor itself
//  Revision    : 1.0  initial release
// ============================================================================
interface serial_sub_if #(
    parameter int WIDTH = 4
);
    logic             start_valid;
    logic             start_ready;
    logic [WIDTH-1:0] data1;
    logic [WIDTH-1:0] data2;
    logic [WIDTH:0]   diff;
    logic             done_valid;
    logic             done_ready;

    modport master (
        output start_valid, data1, data2, done_ready,
        input  start_ready, diff, done_valid
    );

    modport slave (
        input  start_valid, data1, data2, done_ready,
        output start_ready, diff, done_valid
    );
endinterface
`default_nettype wire

// File: rtl/serial_sub.sv
`default_nettype none
// ============================================================================
//  Module      : serial_sub
//  Description : Multi-cycle bit-serial unsigned subtractor, data1 - data2,
//                one bit per clock LSB first with a ripple-borrow flop.
//                diff[WIDTH-1:0] = difference mod 2^WIDTH,
//                diff[WIDTH]     = borrow-out (data1 < data2).
//                Optional macro SERIAL_SUB_SAT_EN: when the final borrow is
//                set, the low bits of diff are forced to zero (saturation).
//  Ports       : clk  - rising-edge clock
//                rst  - synchronous active-high reset
//                bus  - serial_sub_if.slave (operand and result handshakes)
//  Revision    : 1.0  initial release
// ============================================================================
module serial_sub #(
    parameter int WIDTH = 4
) (
    input  wire logic     clk,
    input  wire logic     rst,
    serial_sub_if.slave   bus
);
    localparam int c_CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [c_CW-1:0] c_LAST = c_CW'(WIDTH - 1);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_SHIFT = 2'd1;
    localparam logic [1:0] c_DONE  = 2'd2;

    logic [1:0]       r_state;
    logic [1:0]       w_state_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_r;
    logic [WIDTH:0]   r_diff;
    logic [c_CW-1:0]  r_cnt;
    logic             r_borrow;

    logic             w_d;
    logic             w_borrow_next;
    logic [WIDTH-1:0] w_r_next;
    logic [WIDTH-1:0] w_res_final;
    logic             w_last;
    logic             w_start_ready;
    logic             w_done_valid;

    // One full-subtractor slice on the current LSBs.
    assign w_d           = r_a[0] ^ r_b[0] ^ r_borrow;
    assign w_borrow_next = (~r_a[0] & r_b[0]) | (~(r_a[0] ^ r_b[0]) & r_borrow);
    // New bit enters at the MSB so that after WIDTH shifts bit 0 sits at R[0].
    assign w_r_next      = {w_d, r_r[WIDTH-1:1]};
    assign w_last        = (r_state == c_SHIFT) && (r_cnt == c_LAST);

`ifdef SERIAL_SUB_SAT_EN
    assign w_res_final = w_borrow_next ? '0 : w_r_next;
`else
    assign w_res_final = w_r_next;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_IDLE:  if (bus.start_valid) w_state_next = c_SHIFT;
            c_SHIFT: if (w_last)          w_state_next = c_DONE;
            c_DONE:  if (bus.done_ready)  w_state_next = c_IDLE;
            default:                      w_state_next = c_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        w_start_ready = 1'b0;
        w_done_valid  = 1'b0;
        case (r_state)
            c_IDLE:  w_start_ready = 1'b1;
            c_DONE:  w_done_valid  = 1'b1;
            default: ;
        endcase
    end

    // Datapath: operand shifters, result shifter, borrow flop, bit counter.
    // diff is written only on the last shift, so it holds its value in IDLE
    // and during SHIFT and never shows a partial result.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a      <= '0;
            r_b      <= '0;
            r_r      <= '0;
            r_diff   <= '0;
            r_cnt    <= '0;
            r_borrow <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (bus.start_valid) begin
                        r_a      <= bus.data1;
                        r_b      <= bus.data2;
                        r_borrow <= 1'b0;
                        r_cnt    <= '0;
                    end
                end
                c_SHIFT: begin
                    r_a      <= r_a >> 1;
                    r_b      <= r_b >> 1;
                    r_r      <= w_r_next;
                    r_borrow <= w_borrow_next;
                    r_cnt    <= r_cnt + c_CW'(1);
                    if (w_last) begin
                        r_diff <= {w_borrow_next, w_res_final};
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.start_ready = w_start_ready;
    assign bus.done_valid  = w_done_valid;
    assign bus.diff        = r_diff;

endmodule
`default_nettype wire
